seg_595_scan_multi: RTL and testbench

//  Parametrised N-digit 7-segment scan driver feeding a 74HC595 chain: segments + digit selects.
//  Per-digit hex data, DP, blank mask, leading-zero suppression, sign, PWM brightness, frame snapshot.

---
 rtl/seg_595_scan_multi_pkg.sv | 36 +++
 rtl/seg_595_scan_multi_if.sv | 27 ++
 rtl/seg_595_scan_multi_shifter.sv | 91 +++++++++
 rtl/seg_595_scan_multi.sv | 121 ++++++++++++
 tb/tb_seg_595_scan_multi.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/seg_595_scan_multi_pkg.sv
// Shared types, constants and the hex font for the multi-digit 74HC595 scan driver.
package seg_595_scan_multi_pkg;

    typedef enum logic [1:0] {
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        HOLD
    } state_t;

    localparam logic [6:0] SEG_OFF   = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_font = 7'h3F;
            4'h1:    hex_font = 7'h06;
            4'h2:    hex_font = 7'h5B;
            4'h3:    hex_font = 7'h4F;
            4'h4:    hex_font = 7'h66;
            4'h5:    hex_font = 7'h6D;
            4'h6:    hex_font = 7'h7D;
            4'h7:    hex_font = 7'h07;
            4'h8:    hex_font = 7'h7F;
            4'h9:    hex_font = 7'h6F;
            4'hA:    hex_font = 7'h77;
            4'hB:    hex_font = 7'h7C;
            4'hC:    hex_font = 7'h39;
            4'hD:    hex_font = 7'h5E;
            4'hE:    hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

endpackage

// File: rtl/seg_595_scan_multi_if.sv
// Application-side display inputs and 74HC595 pin outputs of the scan driver.
interface seg_595_scan_multi_if #(
    parameter int N_DIG = 6,
    parameter int BRT_W = 4
);
    logic [4*N_DIG-1:0] data;
    logic [N_DIG-1:0]   point;
    logic [N_DIG-1:0]   blank;
    logic               sign;
    logic               seg_en;
    logic [BRT_W-1:0]   brightness;
    logic               shcp;
    logic               stcp;
    logic               ds;
    logic               oe;
    logic               frame_done;

    modport master (
        output data, point, blank, sign, seg_en, brightness,
        input  shcp, stcp, ds, oe, frame_done
    );

    modport slave (
        input  data, point, blank, sign, seg_en, brightness,
        output shcp, stcp, ds, oe, frame_done
    );
endinterface

// File: rtl/seg_595_scan_multi_shifter.sv
// Parallel-load serial engine for a 74HC595 chain: shifts word LSB first, then latches.
// state    | meaning
// SHIFT_LO | ds holds current bit, shcp low
// SHIFT_HI | shcp high, 595 samples ds
// LATCH    | stcp high, chain copied to outputs
// HOLD     | idle until next load
module seg_595_scan_multi_shifter
    import seg_595_scan_multi_pkg::*;
#(
    parameter int CHAIN_W = 14,
    parameter int CLK_DIV = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               load,
    input  logic               load_last,
    input  logic [CHAIN_W-1:0] word,
    output logic               shcp,
    output logic               stcp,
    output logic               ds,
    output logic               busy,
    output logic               done
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(CHAIN_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_W - 1);

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CHAIN_W-1:0] sreg;
    logic               last_q;
    logic               div_end;

    assign div_end = (div_cnt == DIV_LAST);
    assign busy    = (state != HOLD);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= SHIFT_LO;
            div_cnt <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            last_q  <= 1'b0;
            shcp    <= 1'b0;
            stcp    <= 1'b0;
            ds      <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= SHIFT_LO;
                div_cnt <= '0;
                bit_cnt <= '0;
                sreg    <= word;
                last_q  <= load_last;
                ds      <= word[0];
                shcp    <= 1'b0;
                stcp    <= 1'b0;
            end else begin
                div_cnt <= div_end ? '0 : div_cnt + 1'b1;
                case (state)
                    SHIFT_LO: if (div_end) begin
                        state <= SHIFT_HI;
                        shcp  <= 1'b1;
                    end
                    SHIFT_HI: if (div_end) begin
                        shcp <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= LATCH;
                            stcp  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sreg    <= sreg >> 1;
                            ds      <= sreg[1];
                            state   <= SHIFT_LO;
                        end
                    end
                    LATCH: if (div_end) begin
                        state <= HOLD;
                        stcp  <= 1'b0;
                        ds    <= 1'b0;
                        done  <= last_q;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: rtl/seg_595_scan_multi.sv
// N-digit 7-segment scan driver: slot timing, frame snapshot, leading-zero/sign
// handling, digit mux and PWM output enable in front of a 74HC595 shifter.
module seg_595_scan_multi
    import seg_595_scan_multi_pkg::*;
#(
    parameter int N_DIG       = 6,
    parameter int CLK_DIV     = 2,
    parameter int DIG_CYC     = 50000,
    parameter int BRT_W       = 4,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 0,
    parameter int LZ_SUPPRESS = 1
) (
    input logic                sys_clk,
    input logic                sys_rst,
    seg_595_scan_multi_if.slave bus
);
    localparam int CHAIN_W = 8 + N_DIG;
    localparam int IDX_W   = $clog2(N_DIG);
    localparam int SLOT_W  = $clog2(DIG_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

    logic [SLOT_W-1:0]  slot_cnt;
    logic [IDX_W-1:0]   idx;
    logic [4*N_DIG-1:0] snap_data, cur_data;
    logic [N_DIG-1:0]   snap_point, cur_point;
    logic [N_DIG-1:0]   snap_blank, cur_blank;
    logic               snap_sign, cur_sign;
    logic [BRT_W-1:0]   pwm_cnt;
    logic               oe_q;
    logic               load, capture, slot_end, busy;
    logic [N_DIG-1:0]   lz;
    logic               lz_run;
    logic [IDX_W-1:0]   sign_pos;
    logic [3:0]         nib;
    logic [7:0]         seg_on;
    logic [N_DIG-1:0]   sel_on;
    logic [CHAIN_W-1:0] word;

    assign load     = (slot_cnt == '0);
    assign capture  = load && (idx == '0);
    assign slot_end = (slot_cnt == SLOT_W'(DIG_CYC - 1));

    // The digit-0 load uses the live inputs so the snapshot and its first word agree.
    always_comb begin
        cur_data  = capture ? bus.data  : snap_data;
        cur_point = capture ? bus.point : snap_point;
        cur_blank = capture ? bus.blank : snap_blank;
        cur_sign  = capture ? bus.sign  : snap_sign;
    end

    always_comb begin
        lz       = '0;
        lz_run   = (LZ_SUPPRESS != 0);
        sign_pos = IDX_LAST;
        nib      = 4'h0;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            lz_run = lz_run && (cur_data[4*i +: 4] == 4'h0) && !cur_point[i];
            lz[i]  = lz_run;
            if (lz_run) sign_pos = IDX_W'(i);
        end
        for (int i = 0; i < N_DIG; i++) begin
            if (idx == IDX_W'(i)) nib = cur_data[4*i +: 4];
        end
        seg_on = {cur_point[idx], hex_font(nib)};
        if (cur_blank[idx])                     seg_on[6:0] = SEG_OFF;
        else if (cur_sign && idx == sign_pos)   seg_on[6:0] = SEG_MINUS;
        else if (lz[idx])                       seg_on[6:0] = SEG_OFF;
        sel_on      = '0;
        sel_on[idx] = 1'b1;
        word = {(SEL_ACT_LOW != 0) ? ~sel_on : sel_on,
                (SEG_ACT_LOW != 0) ? ~seg_on : seg_on};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            slot_cnt   <= '0;
            idx        <= '0;
            snap_data  <= '0;
            snap_point <= '0;
            snap_blank <= '0;
            snap_sign  <= 1'b0;
            pwm_cnt    <= '0;
            oe_q       <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            // Going dark on the load edge keeps the old digit from ghosting while shifting.
            oe_q <= ~(bus.seg_en && !busy && !load && (pwm_cnt < bus.brightness));
            if (capture) begin
                snap_data  <= bus.data;
                snap_point <= bus.point;
                snap_blank <= bus.blank;
                snap_sign  <= bus.sign;
            end
            if (slot_end) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    assign bus.oe = oe_q;

    seg_595_scan_multi_shifter #(
        .CHAIN_W(CHAIN_W),
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (load),
        .load_last(idx == IDX_LAST),
        .word     (word),
        .shcp     (bus.shcp),
        .stcp     (bus.stcp),
        .ds       (bus.ds),
        .busy     (busy),
        .done     (bus.frame_done)
    );
endmodule

// File: tb/tb_seg_595_scan_multi.sv
// Bench for seg_595_scan_multi: 595 chain decoder against a queue of expected chain words.
module tb_seg_595_scan_multi;
    localparam int N_DIG   = 6;
    localparam int CLK_DIV = 2;
    localparam int DIG_CYC = 100;
    localparam int BRT_W   = 4;
    localparam int CHAIN_W = 8 + N_DIG;

    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [CHAIN_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    seg_595_scan_multi_if #(.N_DIG(N_DIG), .BRT_W(BRT_W)) bus ();

    seg_595_scan_multi #(
        .N_DIG(N_DIG), .CLK_DIV(CLK_DIV), .DIG_CYC(DIG_CYC), .BRT_W(BRT_W),
        .SEG_ACT_LOW(1), .SEL_ACT_LOW(0), .LZ_SUPPRESS(1)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected chain word (bit k = k-th bit shifted) for digit k of a frame.
    function automatic logic [CHAIN_W-1:0] model_word(input logic [4*N_DIG-1:0] d,
            input logic [N_DIG-1:0] p, input logic [N_DIG-1:0] b, input logic s, input int k);
        int f, spos;
        logic [3:0] n;
        logic [7:0] seg;
        logic [N_DIG-1:0] sel;
        f = 0;
        for (int i = 0; i < N_DIG; i++) if (d[4*i +: 4] != 4'h0 || p[i]) f = i;
        spos = (f == N_DIG - 1) ? N_DIG - 1 : f + 1;
        n = d[4*k +: 4];
        if (b[k])                  seg = {p[k], 7'h00};
        else if (s && k == spos)   seg = {p[k], 7'h40};
        else if (k > f)            seg = {p[k], 7'h00};
        else                       seg = {p[k], FONT[n]};
        sel = '0;
        sel[k] = 1'b1;
        return {sel, ~seg};
    endfunction

    task automatic push_frame(input int first);
        for (int k = first; k < N_DIG; k++)
            exp_q.push_back(model_word(bus.data, bus.point, bus.blank, bus.sign, k));
    endtask

    task automatic wait_frame_done(input string tag);
        logic seen = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (bus.frame_done) begin seen = 1'b1; break; end
        end
        check({tag, "_frame_done"}, seen, 1);
    endtask

    task automatic wait_stcp_fall(input string tag);
        logic hi = 1'b0;
        logic ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!hi && bus.stcp) hi = 1'b1;
            else if (hi && !bus.stcp) begin ok = 1'b1; break; end
        end
        check({tag, "_stcp"}, ok, 1);
    endtask

    task automatic measure_pwm(input string tag, input int expv);
        int lows = 0;
        wait_stcp_fall(tag);
        repeat (2) @(negedge clk);
        repeat (16) begin
            @(negedge clk);
            if (bus.oe === 1'b0) lows++;
        end
        check(tag, lows, expv);
    endtask

    // 595 chain decoder: collects ds on shcp rise, pops and compares on stcp rise.
    initial begin : monitor
        logic prev_shcp, prev_stcp;
        logic [CHAIN_W-1:0] sh, e;
        int nbits;
        prev_shcp = 1'b0; prev_stcp = 1'b0; sh = '0; nbits = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nbits = 0; sh = '0; prev_shcp = 1'b0; prev_stcp = 1'b0;
            end else begin
                if (bus.shcp && !prev_shcp) begin
                    if (nbits < CHAIN_W) sh[nbits] = bus.ds;
                    nbits++;
                end
                if (bus.stcp && !prev_stcp) begin
                    check("bit_count", nbits, CHAIN_W);
                    check("sb_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("chain_word", sh, e);
                    end
                    nbits = 0; sh = '0;
                end
                prev_shcp = bus.shcp;
                prev_stcp = bus.stcp;
            end
        end
    end

    initial begin
        bus.data = '0; bus.point = '0; bus.blank = '0; bus.sign = 1'b0;
        bus.seg_en = 1'b1; bus.brightness = 4'd15;
        repeat (3) @(negedge clk);
        check("rst_shcp", bus.shcp, 0);
        check("rst_stcp", bus.stcp, 0);
        check("rst_ds", bus.ds, 0);
        check("rst_oe", bus.oe, 1);
        check("rst_frame_done", bus.frame_done, 0);

        bus.data = 24'h012345;
        push_frame(0);
        rst = 1'b0;
        measure_pwm("pwm_brt15", 15);
        wait_frame_done("lz_012345");

        bus.data = 24'h000008; bus.brightness = 4'd0;
        exp_q.push_back(14'h0180);
        push_frame(1);
        measure_pwm("pwm_brt0", 0);
        wait_frame_done("bit_order");

        bus.data = 24'h000007; bus.sign = 1'b1; bus.brightness = 4'd8;
        push_frame(0);
        measure_pwm("pwm_brt8", 8);
        wait_frame_done("sign_low");

        bus.data = 24'h987654; bus.seg_en = 1'b0; bus.brightness = 4'd15;
        push_frame(0);
        measure_pwm("pwm_seg_en0", 0);
        wait_frame_done("sign_full");

        bus.data = 24'h0000F0; bus.point = 6'b000100; bus.blank = 6'b001000; bus.seg_en = 1'b1;
        push_frame(0);
        measure_pwm("pwm_restore", 15);
        wait_frame_done("point_blank_sign");

        bus.data = 24'h012345; bus.point = '0; bus.blank = '0; bus.sign = 1'b0;
        push_frame(0);
        repeat (3) wait_stcp_fall("mid_frame");
        repeat (50) @(negedge clk);
        bus.data = 24'h00ABCD; bus.point = 6'b000011;
        wait_frame_done("mid_frame_old");
        push_frame(0);
        wait_frame_done("mid_frame_new");

        bus.data = 24'h135790; bus.point = '0;
        push_frame(0);
        repeat (2) wait_stcp_fall("pre_reset");
        begin
            logic hi = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if (bus.shcp) begin hi = 1'b1; break; end
                @(negedge clk);
            end
            check("reach_shift_hi", hi, 1);
        end
        rst = 1'b1;
        #1;
        check("async_shcp", bus.shcp, 0);
        check("async_stcp", bus.stcp, 0);
        check("async_oe", bus.oe, 1);
        check("async_ds", bus.ds, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        bus.data = 24'h246801;
        push_frame(0);
        rst = 1'b0;
        wait_frame_done("after_reset");
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
